// File: rtl/simon_pkg.sv
// Shared definitions for the Simon front-end and game core.
//
// Contents:
//   NUM_BTN             - number of push-buttons (fixed at 4, codes are 2 bits)
//   DEBOUNCE_MS_DEFAULT - default debounce stable time in milliseconds
//   ev_state_t          - event FSM state encoding (IDLE=0, HELD=1, CHORD=2)
//   is_one_hot()        - true when exactly one bit of a button vector is set
//   one_hot_index()     - index of the set bit in a one-hot button vector
package simon_pkg;

    localparam int NUM_BTN             = 4;
    localparam int DEBOUNCE_MS_DEFAULT = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HELD  = 2'd1,
        ST_CHORD = 2'd2
    } ev_state_t;

    // Clearing the lowest set bit leaves zero only when at most one bit was set.
    function automatic logic is_one_hot(input logic [NUM_BTN-1:0] v);
        return (v != '0) && ((v & (v - NUM_BTN'(1))) == '0);
    endfunction

    function automatic logic [1:0] one_hot_index(input logic [NUM_BTN-1:0] v);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (v[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/button_debouncer_ms_timebase.sv
// Millisecond prescaler shared by the debouncer and, later, the game core.
//
// Ports:
//   clk             - system clock
//   rst_n           - asynchronous active-low reset
//   ticks_per_milli - clock ticks per millisecond minus one
//   ms_tick         - one-cycle pulse every ticks_per_milli+1 cycles
//
// If ticks_per_milli drops below the running count, the counter simply runs
// on to 0xFFFF and wraps before matching again.
module ms_timebase (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] ticks_per_milli,
    output logic        ms_tick
);

    logic [15:0] tick_cnt;

    assign ms_tick = (tick_cnt == ticks_per_milli);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (ms_tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Front-end conditioning for the four Simon push-buttons.
//
// Ports:
//   clk             - system clock
//   rst_n           - asynchronous active-low reset
//   ticks_per_milli - prescaler reload (period is ticks_per_milli+1 cycles)
//   btn_raw         - raw asynchronous button pads, active-high
//   btn_clean       - debounced button levels, feeds the game core
//   press_valid     - one-cycle pulse when exactly one button is newly pressed
//   press_code      - index of that button, held until the next press
//   release_valid   - one-cycle pulse when a single valid press is released
//   chord           - high while more than one button has been seen together
module button_debouncer #(
    parameter int DEBOUNCE_MS = simon_pkg::DEBOUNCE_MS_DEFAULT,
    parameter int NUM_BTN     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [15:0]        ticks_per_milli,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_clean,
    output logic               press_valid,
    output logic [1:0]         press_code,
    output logic               release_valid,
    output logic               chord
);

    import simon_pkg::*;

    logic [NUM_BTN-1:0] sync_meta;
    logic [NUM_BTN-1:0] btn_sync;
    logic               ms_tick;
    ev_state_t          state;

    ms_timebase u_timebase (
        .clk             (clk),
        .rst_n           (rst_n),
        .ticks_per_milli (ticks_per_milli),
        .ms_tick         (ms_tick)
    );

    // Two-flop synchroniser for the asynchronous pads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= '0;
            btn_sync  <= '0;
        end else begin
            sync_meta <= btn_raw;
            btn_sync  <= sync_meta;
        end
    end

    // Each button accepts a new level only after it has disagreed with the
    // clean level for DEBOUNCE_MS+1 consecutive ms ticks; any bounce back
    // to the clean level restarts the window.
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
        logic [7:0] db_cnt;
        logic       clean_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                db_cnt  <= '0;
                clean_q <= 1'b0;
            end else if (btn_sync[i] == clean_q) begin
                db_cnt <= '0;
            end else if (ms_tick) begin
                if (db_cnt == 8'(DEBOUNCE_MS)) begin
                    clean_q <= btn_sync[i];
                    db_cnt  <= '0;
                end else begin
                    db_cnt <= db_cnt + 8'd1;
                end
            end
        end

        assign btn_clean[i] = clean_q;
    end

    // Event FSM on the clean levels. Presses are only taken from IDLE, so a
    // held button never repeats, and a chord must fully release before the
    // next press is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            press_valid   <= 1'b0;
            press_code    <= '0;
            release_valid <= 1'b0;
            chord         <= 1'b0;
        end else begin
            press_valid   <= 1'b0;
            release_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (is_one_hot(btn_clean)) begin
                        press_valid <= 1'b1;
                        press_code  <= one_hot_index(btn_clean);
                        state       <= ST_HELD;
                    end else if (btn_clean != '0) begin
                        chord <= 1'b1;
                        state <= ST_CHORD;
                    end
                end
                ST_HELD: begin
                    if (btn_clean == '0) begin
                        release_valid <= 1'b1;
                        state         <= ST_IDLE;
                    end else if (btn_clean != (NUM_BTN'(1) << press_code)) begin
                        chord <= 1'b1;
                        state <= ST_CHORD;
                    end
                end
                ST_CHORD: begin
                    if (btn_clean == '0) begin
                        chord <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    chord <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: one instance with a 5-cycle ms and a
// 3 ms window, one instance with a 1-cycle ms and a 1 ms window.
module tb_button_debouncer;

    logic        clk;
    logic        rst_n;
    logic [15:0] tpmA;
    logic [3:0]  rawA;
    logic [3:0]  cleanA;
    logic        pressA;
    logic [1:0]  codeA;
    logic        releaseA;
    logic        chordA;

    logic [15:0] tpmB;
    logic [3:0]  rawB;
    logic [3:0]  cleanB;
    logic        pressB;
    logic [1:0]  codeB;
    logic        releaseB;
    logic        chordB;

    int checkCount = 0;
    int errorCount = 0;
    int pressCountA = 0;
    int releaseCountA = 0;
    int overlapCount = 0;

    button_debouncer #(.DEBOUNCE_MS(3), .NUM_BTN(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ticks_per_milli (tpmA),
        .btn_raw         (rawA),
        .btn_clean       (cleanA),
        .press_valid     (pressA),
        .press_code      (codeA),
        .release_valid   (releaseA),
        .chord           (chordA)
    );

    button_debouncer #(.DEBOUNCE_MS(1), .NUM_BTN(4)) dutFast (
        .clk             (clk),
        .rst_n           (rst_n),
        .ticks_per_milli (tpmB),
        .btn_raw         (rawB),
        .btn_clean       (cleanB),
        .press_valid     (pressB),
        .press_code      (codeB),
        .release_valid   (releaseB),
        .chord           (chordB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event counters sampled on the active edge (pre-update values).
    always @(posedge clk) begin
        if (pressA) pressCountA++;
        if (releaseA) releaseCountA++;
        if ((pressA && releaseA) || (pressB && releaseB)) overlapCount++;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkRange(input string tag, input int observed, input int lo, input int hi);
        checkCount++;
        assert (observed >= lo && observed <= hi) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d..%0d", tag, observed, lo, hi);
        end
    endtask

    // Drive raw pads on the falling edge, away from the sampling edge.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        rawA = a;
        rawB = b;
    endtask

    // Count falling edges until the selected clean bus equals target.
    task automatic waitClean(input bit fast, input logic [3:0] target, output int lat);
        bit done;
        done = 1'b0;
        lat  = 0;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
            if ((fast ? cleanB : cleanA) == target) done = 1'b1;
        end
        if (!done) lat = 999;
    endtask

    initial begin
        int lat;
        int pc;
        int rc;
        int bounceBad;

        rst_n = 1'b0;
        tpmA  = 16'd4;
        tpmB  = 16'd0;
        rawA  = '0;
        rawB  = '0;
        #23;
        checkOutput("reset_clean", cleanA, 0);
        checkOutput("reset_press", pressA, 0);
        checkOutput("reset_code", codeA, 0);
        checkOutput("reset_release", releaseA, 0);
        checkOutput("reset_chord", chordA, 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] single press of button 0");
        applyStimulus(4'b0001, 4'b0000);
        pc = pressCountA;
        waitClean(1'b0, 4'b0001, lat);
        checkRange("press0_latency", lat, 17, 22);
        checkOutput("press0_pulse_early", pressA, 0);
        @(negedge clk);
        checkOutput("press0_pulse", pressA, 1);
        checkOutput("press0_code", codeA, 0);
        @(negedge clk);
        checkOutput("press0_pulse_end", pressA, 0);
        repeat (30) @(negedge clk);
        checkOutput("press0_no_repeat", pressCountA - pc, 1);

        $display("[TB] release of button 0");
        applyStimulus(4'b0000, 4'b0000);
        waitClean(1'b0, 4'b0000, lat);
        @(negedge clk);
        checkOutput("release0_pulse", releaseA, 1);
        @(negedge clk);
        checkOutput("release0_pulse_end", releaseA, 0);

        $display("[TB] bouncing button 2");
        pc = pressCountA;
        bounceBad = 0;
        for (int k = 0; k < 63; k++) begin
            applyStimulus(((k / 7) % 2 == 1) ? 4'b0100 : 4'b0000, 4'b0000);
            if (cleanA[2] !== 1'b0) bounceBad++;
        end
        applyStimulus(4'b0100, 4'b0000);
        checkOutput("bounce_clean_low", bounceBad, 0);
        waitClean(1'b0, 4'b0100, lat);
        checkRange("bounce_latency", lat, 17, 22);
        repeat (5) @(negedge clk);
        checkOutput("bounce_press_count", pressCountA - pc, 1);
        checkOutput("bounce_code", codeA, 2);
        applyStimulus(4'b0000, 4'b0000);
        waitClean(1'b0, 4'b0000, lat);
        repeat (3) @(negedge clk);

        $display("[TB] chord of buttons 1 and 3");
        rc = releaseCountA;
        applyStimulus(4'b0010, 4'b0000);
        waitClean(1'b0, 4'b0010, lat);
        @(negedge clk);
        checkOutput("chord_first_press", pressA, 1);
        checkOutput("chord_first_code", codeA, 1);
        repeat (9) @(negedge clk);
        applyStimulus(4'b1010, 4'b0000);
        waitClean(1'b0, 4'b1010, lat);
        checkOutput("chord_low_before", chordA, 0);
        @(negedge clk);
        checkOutput("chord_high", chordA, 1);
        applyStimulus(4'b0000, 4'b0000);
        waitClean(1'b0, 4'b0000, lat);
        @(negedge clk);
        checkOutput("chord_dropped", chordA, 0);
        repeat (3) @(negedge clk);
        checkOutput("chord_no_release", releaseCountA - rc, 0);

        $display("[TB] press, release, press of button 3");
        applyStimulus(4'b1000, 4'b0000);
        waitClean(1'b0, 4'b1000, lat);
        @(negedge clk);
        checkOutput("b3_press", pressA, 1);
        checkOutput("b3_code", codeA, 3);
        applyStimulus(4'b0000, 4'b0000);
        waitClean(1'b0, 4'b0000, lat);
        @(negedge clk);
        checkOutput("b3_release", releaseA, 1);
        checkOutput("b3_release_no_press", pressA, 0);
        pc = pressCountA;
        applyStimulus(4'b1000, 4'b0000);
        waitClean(1'b0, 4'b1000, lat);
        @(negedge clk);
        checkOutput("b3_repress", pressA, 1);
        checkOutput("b3_repress_code", codeA, 3);
        applyStimulus(4'b0000, 4'b0000);
        waitClean(1'b0, 4'b0000, lat);
        repeat (3) @(negedge clk);
        checkOutput("b3_repress_count", pressCountA - pc, 1);

        $display("[TB] fast timebase instance");
        applyStimulus(4'b0000, 4'b0001);
        waitClean(1'b1, 4'b0001, lat);
        checkRange("fast_latency", lat, 3, 4);
        @(negedge clk);
        checkOutput("fast_press", pressB, 1);
        checkOutput("fast_code", codeB, 0);

        $display("[TB] reset mid debounce window");
        applyStimulus(4'b0100, 4'b0001);
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_clean", cleanA, 0);
        checkOutput("rst_code", codeA, 0);
        checkOutput("rst_press", pressA, 0);
        checkOutput("rst_chord", chordA, 0);
        checkOutput("rst_fast_clean", cleanB, 0);
        @(negedge clk);
        rst_n = 1'b1;
        waitClean(1'b0, 4'b0100, lat);
        checkOutput("rst_full_redebounce", lat, 20);
        @(negedge clk);
        checkOutput("rst_press_after", pressA, 1);
        checkOutput("rst_code_after", codeA, 2);

        checkOutput("no_press_release_overlap", overlapCount, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
